// File: rtl/mchan_ext_pkg.sv
// Shared MCHAN external-path types: TID, pool size and occupancy count.
package mchan_ext_pkg;

   localparam int unsigned EXT_TID_WIDTH = 4;
   localparam int unsigned EXT_TID_NUM   = 2**EXT_TID_WIDTH;

   typedef logic [EXT_TID_WIDTH-1:0] ext_tid_t;
   typedef logic [EXT_TID_WIDTH:0]   ext_tid_cnt_t;

endpackage : mchan_ext_pkg

// File: rtl/ext_tid_pick.sv
// Rotating priority finder: the first set bit of i_free at or after i_start, wrapping.
module ext_tid_pick #(
   parameter int unsigned W = 4
) (
   input  logic [(1<<W)-1:0] i_free,
   input  logic [W-1:0]      i_start,
   output logic              o_found,
   output logic [W-1:0]      o_idx
);

   localparam int unsigned N = 1 << W;

   // Scan from the farthest offset down to the nearest, so the nearest hit wins.
   always_comb begin
      logic [W-1:0] w_cand;
      o_found = 1'b0;
      o_idx   = '0;
      w_cand  = '0;
      for (int i = N - 1; i >= 0; i--) begin
         w_cand = i_start + W'(i);
         if (i_free[w_cand]) begin
            o_found = 1'b1;
            o_idx   = w_cand;
         end
      end
   end

endmodule : ext_tid_pick

// File: rtl/ext_tid_alloc.sv
// External TID allocator for the MCHAN AXI-side command path.
// Optional build macro EXT_TID_ALLOC_RR_EN: round-robin search starting at a
// pointer that advances past each granted TID; otherwise lowest free TID wins.
module ext_tid_alloc #(
   parameter int unsigned EXT_TID_WIDTH = mchan_ext_pkg::EXT_TID_WIDTH
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     alloc_req_i,
   output logic                     alloc_gnt_o,
   output logic [EXT_TID_WIDTH-1:0] alloc_tid_o,
   input  logic                     release_valid_i,
   input  logic [EXT_TID_WIDTH-1:0] release_tid_i,
   output logic                     busy_o,
   output logic                     full_o,
   output logic [EXT_TID_WIDTH:0]   outstanding_cnt_o,
   output logic                     err_release_o
);

   import mchan_ext_pkg::*;

   localparam int unsigned TID_W = EXT_TID_WIDTH;
   localparam int unsigned CNT_W = EXT_TID_WIDTH + 1;
   localparam int unsigned NUM   = 1 << EXT_TID_WIDTH;

   logic [NUM-1:0]   r_busy;
   logic [CNT_W-1:0] r_cnt;
   logic             r_err;

   logic [NUM-1:0]   w_busy_d;
   logic [CNT_W-1:0] w_cnt_d;
   logic [TID_W-1:0] w_start;
   logic [TID_W-1:0] w_idx;
   logic             w_found;
   logic             w_full;
   logic             w_gnt;
   logic             w_rel_ok;
   logic             w_rel_bad;

`ifdef EXT_TID_ALLOC_RR_EN
   logic [TID_W-1:0] r_ptr;

   // Round-robin pointer moves one past every granted TID.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)    r_ptr <= '0;
      else if (w_gnt) r_ptr <= alloc_tid_o + TID_W'(1);
   end

   assign w_start = r_ptr;
`else
   assign w_start = '0;
`endif

   ext_tid_pick #(
      .W (TID_W)
   ) u_pick (
      .i_free  (~r_busy),
      .i_start (w_start),
      .o_found (w_found),
      .o_idx   (w_idx)
   );

   assign w_full    = (r_cnt == CNT_W'(NUM));
   assign w_gnt     = alloc_req_i & ~w_full;
   assign w_rel_ok  = release_valid_i &  r_busy[release_tid_i];
   assign w_rel_bad = release_valid_i & ~r_busy[release_tid_i];

   assign alloc_gnt_o       = w_gnt;
   assign alloc_tid_o       = w_found ? w_idx : '0;
   assign full_o            = w_full;
   assign busy_o            = (r_cnt != '0);
   assign outstanding_cnt_o = r_cnt;
   assign err_release_o     = r_err;

   // Next bitmap and count; a granted TID is always free so set/clear never collide.
   always_comb begin
      w_busy_d = r_busy;
      w_cnt_d  = r_cnt;
      if (w_gnt)    w_busy_d[alloc_tid_o]   = 1'b1;
      if (w_rel_ok) w_busy_d[release_tid_i] = 1'b0;
      if (w_gnt && !w_rel_ok)      w_cnt_d = r_cnt + CNT_W'(1);
      else if (!w_gnt && w_rel_ok) w_cnt_d = r_cnt - CNT_W'(1);
   end

   // Pool state and one-cycle error pulse.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_busy <= '0;
         r_cnt  <= '0;
         r_err  <= 1'b0;
      end else begin
         r_busy <= w_busy_d;
         r_cnt  <= w_cnt_d;
         r_err  <= w_rel_bad;
      end
   end

   // Occupancy counter must always match the bitmap population.
   always @(posedge clk_i) begin
      if (rst_ni) assert (r_cnt == CNT_W'($countones(r_busy)));
   end

endmodule : ext_tid_alloc

// File: tb/tb_ext_tid_alloc.sv
// Directed bench for ext_tid_alloc with a 4-entry pool.
module tb_ext_tid_alloc;

   localparam int unsigned W = 2;

   logic         clk_i = 1'b0;
   logic         rst_ni;
   logic         alloc_req_i;
   logic         alloc_gnt_o;
   logic [W-1:0] alloc_tid_o;
   logic         release_valid_i;
   logic [W-1:0] release_tid_i;
   logic         busy_o;
   logic         full_o;
   logic [W:0]   outstanding_cnt_o;
   logic         err_release_o;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk_i = ~clk_i;

   ext_tid_alloc #(.EXT_TID_WIDTH(W)) dut (
      .clk_i             (clk_i),
      .rst_ni            (rst_ni),
      .alloc_req_i       (alloc_req_i),
      .alloc_gnt_o       (alloc_gnt_o),
      .alloc_tid_o       (alloc_tid_o),
      .release_valid_i   (release_valid_i),
      .release_tid_i     (release_tid_i),
      .busy_o            (busy_o),
      .full_o            (full_o),
      .outstanding_cnt_o (outstanding_cnt_o),
      .err_release_o     (err_release_o)
   );

   typedef struct {
      logic       req;
      logic       rv;
      logic [1:0] rtid;
      logic       e_gnt;
      logic [1:0] e_tid;
      logic [2:0] e_cnt;
      logic       e_full;
      logic       e_busy;
      logic       e_err;
   } vec_t;

   vec_t tbl[$];

   task automatic check(input string name, input int step, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s step %0d: got %0d expected %0d", name, step, act, exp);
      end
   endtask

   task automatic add(input logic req, input logic rv, input logic [1:0] rtid,
                      input logic gnt, input logic [1:0] tid, input logic [2:0] cnt,
                      input logic full, input logic busy, input logic err);
      vec_t v;
      v.req = req; v.rv = rv; v.rtid = rtid;
      v.e_gnt = gnt; v.e_tid = tid; v.e_cnt = cnt;
      v.e_full = full; v.e_busy = busy; v.e_err = err;
      tbl.push_back(v);
   endtask

   // Drive on the falling edge, sample 1ns later, then let the rising edge commit.
   task automatic apply(input int step, input vec_t v);
      @(negedge clk_i);
      alloc_req_i     = v.req;
      release_valid_i = v.rv;
      release_tid_i   = v.rtid;
      #1;
      check("gnt",  step, int'(alloc_gnt_o),       int'(v.e_gnt));
      check("tid",  step, int'(alloc_tid_o),       int'(v.e_tid));
      check("cnt",  step, int'(outstanding_cnt_o), int'(v.e_cnt));
      check("full", step, int'(full_o),            int'(v.e_full));
      check("busy", step, int'(busy_o),            int'(v.e_busy));
      check("err",  step, int'(err_release_o),     int'(v.e_err));
   endtask

   task automatic do_reset();
      alloc_req_i = 1'b0; release_valid_i = 1'b0; release_tid_i = '0;
      rst_ni = 1'b0;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      rst_ni = 1'b1;
   endtask

   initial begin
      //    req rv rtid | gnt tid cnt full busy err
`ifdef EXT_TID_ALLOC_RR_EN
      add(0, 0, 0,   0, 0, 0, 0, 0, 0);   // reset state
      add(1, 0, 0,   1, 0, 0, 0, 0, 0);   // grant 0
      add(1, 0, 0,   1, 1, 1, 0, 1, 0);   // grant 1
      add(0, 1, 0,   0, 2, 2, 0, 1, 0);   // release 0, pointer at 2
      add(1, 0, 0,   1, 2, 1, 0, 1, 0);   // 2 granted, not 0
      add(1, 0, 0,   1, 3, 2, 0, 1, 0);   // grant 3
      add(1, 0, 0,   1, 0, 3, 0, 1, 0);   // pointer wrapped: 0
      add(1, 0, 0,   0, 0, 4, 1, 1, 0);   // full
      add(0, 1, 1,   0, 0, 4, 1, 1, 0);   // release 1
      add(0, 0, 0,   0, 1, 3, 0, 1, 0);   // visible next cycle
`else
      add(0, 0, 0,   0, 0, 0, 0, 0, 0);   // reset state
      add(1, 0, 0,   1, 0, 0, 0, 0, 0);   // grant 0
      add(1, 0, 0,   1, 1, 1, 0, 1, 0);   // grant 1
      add(1, 0, 0,   1, 2, 2, 0, 1, 0);   // grant 2
      add(1, 0, 0,   1, 3, 3, 0, 1, 0);   // grant 3
      add(1, 0, 0,   0, 0, 4, 1, 1, 0);   // 5th request refused
      add(0, 1, 2,   0, 0, 4, 1, 1, 0);   // release 2, not yet visible
      add(1, 0, 0,   1, 2, 3, 0, 1, 0);   // 2 regranted
      add(0, 1, 3,   0, 0, 4, 1, 1, 0);   // release 3
      add(0, 1, 2,   0, 3, 3, 0, 1, 0);   // release 2
      add(0, 1, 1,   0, 2, 2, 0, 1, 0);   // release 1 -> only 0 busy
      add(1, 1, 0,   1, 1, 1, 0, 1, 0);   // grant 1 + release 0
      add(0, 1, 3,   0, 0, 1, 0, 1, 0);   // busy=0010, bogus release 3
      add(0, 0, 0,   0, 0, 1, 0, 1, 1);   // err pulse, state unchanged
      add(1, 0, 0,   1, 0, 1, 0, 1, 0);   // pulse gone, grant 0
      add(1, 1, 2,   1, 2, 2, 0, 1, 0);   // release of TID being granted
      add(0, 0, 0,   0, 3, 3, 0, 1, 1);   // err, grant still completed
      add(0, 0, 0,   0, 3, 3, 0, 1, 0);
`endif

      do_reset();
      foreach (tbl[i]) apply(i, tbl[i]);

      // Reset with three outstanding, then a stale response arrives.
      do_reset();
      @(negedge clk_i);
      alloc_req_i = 1'b1;
      repeat (3) @(negedge clk_i);
      alloc_req_i = 1'b0;
      #1;
      check("pre_rst_cnt", 0, int'(outstanding_cnt_o), 3);
      rst_ni = 1'b0;
      #1;
      check("rst_cnt",  0, int'(outstanding_cnt_o), 0);
      check("rst_busy", 0, int'(busy_o),            0);
      check("rst_full", 0, int'(full_o),            0);
      check("rst_tid",  0, int'(alloc_tid_o),       0);
      check("rst_err",  0, int'(err_release_o),     0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      release_valid_i = 1'b1;
      release_tid_i   = 2'd1;
      @(negedge clk_i);
      release_valid_i = 1'b0;
      begin : wait_err
         bit seen = 1'b0;
         for (int c = 0; c < 3 && !seen; c++) begin
            #1;
            if (err_release_o) seen = 1'b1;
            else @(negedge clk_i);
         end
         check("stale_err", 0, int'(seen), 1);
      end
      check("stale_cnt", 0, int'(outstanding_cnt_o), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_ext_tid_alloc

// File: doc/ext_tid_alloc.md
# ext_tid_alloc

Transaction-ID allocator for the MCHAN external (AXI-side) command path. It owns the pool of 2^EXT_TID_WIDTH external TIDs. It hands a free TID to each outgoing external command, and that grant is the write strobe and index for the TID-indexed opcode buffer. It reclaims the TID when the external response for that transaction completes. It also exposes occupancy and error status so the command issuer can stall when no TID is free.

## Interface
Parameters:
- EXT_TID_WIDTH, 4: TID width; the pool holds 2^EXT_TID_WIDTH entries.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- alloc_req_i  in  1  issuer requests a TID for a new external command
- alloc_gnt_o  out  1  TID granted this cycle; drives the opcode-buffer write valid
- alloc_tid_o  out  EXT_TID_WIDTH  granted TID; drives the opcode-buffer write index
- release_valid_i  in  1  response for a TID completed (last beat accepted)
- release_tid_i  in  EXT_TID_WIDTH  TID being released
- busy_o  out  1  at least one TID is outstanding
- full_o  out  1  all TIDs are outstanding
- outstanding_cnt_o  out  EXT_TID_WIDTH+1  number of outstanding TIDs
- err_release_o  out  1  one-cycle pulse: a release hit a TID that was not outstanding

## Operation
- State:
  - busy bitmap busy_q[2^EXT_TID_WIDTH-1:0]
  - counter cnt_q
  - err_q
  - round-robin pointer ptr_q (only when the macro is defined)
- Free set = ~busy_q. Selection is combinational from the registered state only.
- alloc_gnt_o = alloc_req_i & ~full_o.
- alloc_tid_o = selected free TID. It is 0 when full_o = 1.
- On a grant, busy_q[alloc_tid_o] is set at the next edge and cnt_q increments.
- On release_valid_i with busy_q[release_tid_i] = 1:
  - the bit clears at the next edge;
  - cnt_q decrements.
- On release_valid_i with busy_q[release_tid_i] = 0:
  - no state change;
  - err_q is set for exactly one cycle.
- Simultaneous grant and valid release:
  - both take effect;
  - cnt_q is unchanged;
  - the released TID is not eligible for allocation until the following cycle.
- Release of the TID being granted in the same cycle counts as invalid, because that bit is still 0 in busy_q: err pulse, and the grant still completes.
- full_o = (cnt_q == 2^EXT_TID_WIDTH).
- busy_o = (cnt_q != 0).
- Invariant, checked by an assertion: cnt_q == popcount(busy_q).
- Reset values:
  - busy_q = 0, cnt_q = 0, err_q = 0, ptr_q = 0;
  - hence full_o = 0, busy_o = 0, alloc_tid_o = 0, err_release_o = 0;
  - alloc_gnt_o follows alloc_req_i.
- Reset mid-operation frees all TIDs immediately. Responses still in flight then produce err pulses, and the issuer must be reset together with this block.

## Timing
- Grant is zero-latency: combinational from alloc_req_i and registered state, with no path from release_valid_i.
- A release becomes visible to full_o, outstanding_cnt_o and allocation one cycle after release_valid_i.
- err_release_o is registered: it asserts in the cycle after the offending release.
- Back-to-back grants every cycle are supported until full.
- Wrap-around, only when the macro is defined: after a grant to TID t, ptr_q = t+1 mod 2^EXT_TID_WIDTH.

## Configuration
- EXT_TID_ALLOC_RR_EN defined:
  - the free TID is searched starting at ptr_q, wrapping at 2^EXT_TID_WIDTH;
  - ptr_q advances past each granted TID.
  - This spreads TID reuse so a late duplicate response is more likely to be caught by err_release_o.
- Not defined:
  - the lowest-index free TID is selected;
  - no ptr_q register exists.

## Structure
- Shared package mchan_ext_pkg holds:
  - typedef ext_tid_t, logic [EXT_TID_WIDTH-1:0];
  - localparam EXT_TID_NUM = 2**EXT_TID_WIDTH;
  - the count typedef ext_tid_cnt_t.
- Sub-module ext_tid_pick: parameterized rotating priority finder.
  - Inputs: free vector, start index (tied to 0 when the macro is undefined).
  - Outputs: found flag, index.

## Test plan
All scenarios use EXT_TID_WIDTH = 2 (4 TIDs).
- Reset, then alloc_req_i held high for 4 cycles:
  - without the macro, TIDs granted in order 0,1,2,3;
  - full_o = 1 after the 4th edge;
  - a 5th request gives alloc_gnt_o = 0 and alloc_tid_o = 0;
  - outstanding_cnt_o = 4.
- Full pool, release TID 2 → next cycle full_o = 0 and cnt = 3; the next request is granted TID 2.
- In the same cycle, grant TID 1 and release TID 0 (outstanding) → cnt unchanged; TID 0 is not granted in that cycle; busy_q = 4'b0010 afterwards.
- Release TID 3 while it is free → err_release_o pulses for 1 cycle after; cnt and busy_q are unchanged.
- EXT_TID_ALLOC_RR_EN defined:
  - grant 0,1, release 0, request again → TID 2 is granted, not 0;
  - after TID 3, the pointer wraps and TID 0 is the next pick.
- Assert rst_ni with 3 TIDs outstanding → all outputs at reset values immediately; a subsequent release of TID 1 produces an err pulse.
